regbank_wb_queue: RTL and testbench

//  Writeback queue in front of the 32x32 register bank's single write port.

---
 rtl/regbank_wb_queue.sv | 140 ++++++++++++++
 tb/tb_regbank_wb_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_wb_queue.sv
// regbank_wb_queue: in-order writeback FIFO between the ALU/load producers and
// the register bank's single write port. One entry drains per cycle; the head
// is presented combinationally on write/dr/wrData.
// Optional forwarding lookup of the youngest pending write is enabled by
// defining WBQ_FWD_EN.
module regbank_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [AW-1:0]              ld_dr,
    input  logic [DW-1:0]              ld_data,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [AW-1:0]              alu_dr,
    input  logic [DW-1:0]              alu_data,
    output logic                       write,
    output logic [AW-1:0]              dr,
    output logic [DW-1:0]              wrData,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic [AW-1:0]              sr1,
    input  logic [AW-1:0]              sr2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [DW-1:0]              fwd_data1,
    output logic [DW-1:0]              fwd_data2
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW:0] ONE_W   = (CW + 1)'(1);
    localparam logic [CW:0] TWO_W   = (CW + 1)'(2);

    logic [AW-1:0] mem_dr   [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          nonempty;
    logic [CW:0]   free;
    logic          ld_push;
    logic          alu_push;
    logic [PW-1:0] alu_ptr;

    // The head slot frees up at this edge when the queue is non-empty, so it
    // counts as available for a same-cycle push.
    assign nonempty  = (count_q != '0);
    assign free      = DEPTH_W - {1'b0, count_q} + {{CW{1'b0}}, nonempty};
    assign ld_ready  = !flush && (free >= ONE_W);
    assign alu_ready = !flush && ((free >= TWO_W) || ((free == ONE_W) && !ld_valid));
    assign ld_push   = ld_valid && ld_ready;
    assign alu_push  = alu_valid && alu_ready;
    // The ALU entry lands behind a same-cycle load entry, so it is younger.
    assign alu_ptr   = wr_ptr_q + PW'(ld_push);

    // Drain side: head entry drives the regbank whenever anything is queued.
    assign write  = nonempty;
    assign dr     = nonempty ? mem_dr[rd_ptr_q]   : '0;
    assign wrData = nonempty ? mem_data[rd_ptr_q] : '0;
    assign count  = count_q;

    // Next-state for pointers and occupancy; flush empties the queue.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(nonempty);
        wr_ptr_d = wr_ptr_q + PW'(ld_push) + PW'(alu_push);
        count_d  = count_q + CW'(ld_push) + CW'(alu_push) - CW'(nonempty);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        if (ld_push) begin
            mem_dr[wr_ptr_q]   <= ld_dr;
            mem_data[wr_ptr_q] <= ld_data;
        end
        if (alu_push) begin
            mem_dr[alu_ptr]   <= alu_dr;
            mem_data[alu_ptr] <= alu_data;
        end
    end

`ifdef WBQ_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Scan oldest to youngest so the last match seen is the youngest entry.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (mem_dr[fwd_idx] == sr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = mem_data[fwd_idx];
                end
                if (mem_dr[fwd_idx] == sr2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = mem_data[fwd_idx];
                end
            end
        end
    end
`else
    logic unused_sr;
    assign unused_sr = ^{sr1, sr2};
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_regbank_wb_queue.sv
// Directed self-checking bench for regbank_wb_queue (DEPTH=4, AW=5, DW=32).
module tb_regbank_wb_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        ld_valid, alu_valid;
    logic        ld_ready, alu_ready;
    logic [4:0]  ld_dr, alu_dr, dr, sr1, sr2;
    logic [31:0] ld_data, alu_data, wrData, fwd_data1, fwd_data2;
    logic        write, fwd_hit1, fwd_hit2;
    logic [2:0]  count;

    int ncmp  = 0;
    int nfail = 0;

    logic        logging = 1'b0;
    logic [4:0]  log_dr[$];
    logic [31:0] log_data[$];

    regbank_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dr(ld_dr), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dr(alu_dr), .alu_data(alu_data),
        .write(write), .dr(dr), .wrData(wrData), .count(count),
        .sr1(sr1), .sr2(sr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    always #5 clk = ~clk;

    // Each head is presented for exactly one cycle; capture it mid-cycle.
    always @(negedge clk) begin
        if (logging && write) begin
            log_dr.push_back(dr);
            log_data.push_back(wrData);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        ncmp++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid  = 1'b0;
        alu_valid = 1'b0;
        flush     = 1'b0;
    endtask

    logic [31:0] exp_d[10];
    logic [4:0]  exp_r[10];
    logic        exp_alu_rdy[6];
    logic [2:0]  exp_cnt[6];
    logic        lp, ap;
    int          li, ai;

    initial begin
        reset = 1'b0; flush = 1'b0;
        ld_valid = 1'b0; ld_dr = '0; ld_data = '0;
        alu_valid = 1'b0; alu_dr = '0; alu_data = '0;
        sr1 = '0; sr2 = '0;
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_dr", 64'(dr), 64'd0);
        chk("rst_wrData", 64'(wrData), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single load into empty queue
        ld_valid = 1'b1; ld_dr = 5'd5; ld_data = 32'hA5;
        #1;
        chk("t2_ld_ready", 64'(ld_ready), 64'd1);
        tick();
        idle_inputs();
        #1;
        chk("t2_write", 64'(write), 64'd1);
        chk("t2_dr", 64'(dr), 64'd5);
        chk("t2_wrData", 64'(wrData), 64'hA5);
        chk("t2_count1", 64'(count), 64'd1);
        tick();
        chk("t2_count0", 64'(count), 64'd0);
        chk("t2_write0", 64'(write), 64'd0);

        // Load and ALU to the same register in one cycle
        ld_valid = 1'b1; ld_dr = 5'd3; ld_data = 32'h11;
        alu_valid = 1'b1; alu_dr = 5'd3; alu_data = 32'h22;
        #1;
        chk("t3_alu_ready", 64'(alu_ready), 64'd1);
        tick();
        idle_inputs();
        #1;
        chk("t3_count2", 64'(count), 64'd2);
        chk("t3_first_dr", 64'(dr), 64'd3);
        chk("t3_first_data", 64'(wrData), 64'h11);
        tick();
        chk("t3_second_dr", 64'(dr), 64'd3);
        chk("t3_second_data", 64'(wrData), 64'h22);
        tick();
        chk("t3_count0", 64'(count), 64'd0);

        // Both sources valid every cycle: saturation and ordering
        exp_alu_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_cnt     = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
        exp_d = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h202,
                  32'h103, 32'h104, 32'h105, 32'h203};
        exp_r = '{5'd1, 5'd2, 5'd1, 5'd2, 5'd1, 5'd2, 5'd1, 5'd1, 5'd1, 5'd2};
        log_dr.delete(); log_data.delete();
        logging = 1'b1;
        li = 0; ai = 0;
        for (int c = 0; c < 6; c++) begin
            ld_valid = 1'b1; ld_dr = 5'd1; ld_data = 32'h100 + 32'(li);
            alu_valid = 1'b1; alu_dr = 5'd2; alu_data = 32'h200 + 32'(ai);
            #1;
            chk($sformatf("t4_count_c%0d", c), 64'(count), 64'(exp_cnt[c]));
            chk($sformatf("t4_ld_ready_c%0d", c), 64'(ld_ready), 64'd1);
            chk($sformatf("t4_alu_ready_c%0d", c), 64'(alu_ready), 64'(exp_alu_rdy[c]));
            lp = ld_ready; ap = alu_ready;
            tick();
            if (lp) li++;
            if (ap) ai++;
        end
        ld_valid = 1'b0;
        alu_data = 32'h200 + 32'(ai);
        #1;
        chk("t4_last_slot_alu", 64'(alu_ready), 64'd1);
        tick();
        idle_inputs();
        #1;
        chk("t4_full", 64'(count), 64'd4);
        for (int k = 0; k < 5; k++) tick();
        logging = 1'b0;
        chk("t4_log_size", 64'(log_data.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < log_data.size()) begin
                chk($sformatf("t4_order_data%0d", i), 64'(log_data[i]), 64'(exp_d[i]));
                chk($sformatf("t4_order_dr%0d", i), 64'(log_dr[i]), 64'(exp_r[i]));
            end
        end

        // Flush with three queued entries and a pending ALU result
        log_dr.delete(); log_data.delete();
        logging = 1'b1;
        ld_valid = 1'b1; ld_dr = 5'd4; ld_data = 32'h31;
        alu_valid = 1'b1; alu_dr = 5'd5; alu_data = 32'h32;
        tick();
        ld_data = 32'h33; alu_data = 32'h34;
        tick();
        idle_inputs();
        #1;
        chk("t5_count3", 64'(count), 64'd3);
        flush = 1'b1;
        alu_valid = 1'b1; alu_dr = 5'd6; alu_data = 32'h99;
        #1;
        chk("t5_alu_ready", 64'(alu_ready), 64'd0);
        chk("t5_ld_ready", 64'(ld_ready), 64'd0);
        chk("t5_head_write", 64'(write), 64'd1);
        chk("t5_head_dr", 64'(dr), 64'd5);
        chk("t5_head_data", 64'(wrData), 64'h32);
        tick();
        idle_inputs();
        #1;
        chk("t5_count0", 64'(count), 64'd0);
        chk("t5_write0", 64'(write), 64'd0);
        tick(); tick();
        logging = 1'b0;
        chk("t5_log_size", 64'(log_data.size()), 64'd2);

        // Asynchronous reset with three queued entries
        ld_valid = 1'b1; ld_dr = 5'd1; ld_data = 32'h10;
        alu_valid = 1'b1; alu_dr = 5'd2; alu_data = 32'h20;
        tick();
        ld_data = 32'h11; alu_data = 32'h21;
        tick();
        idle_inputs();
        #1;
        chk("t1_count3", 64'(count), 64'd3);
        reset = 1'b0;
        #1;
        chk("t1_async_count", 64'(count), 64'd0);
        chk("t1_async_write", 64'(write), 64'd0);
        chk("t1_async_dr", 64'(dr), 64'd0);
        chk("t1_async_wrData", 64'(wrData), 64'd0);
        tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("t1_after_release", 64'(count), 64'd0);

        // Forwarding lookup
        ld_valid = 1'b1; ld_dr = 5'd7; ld_data = 32'h1;
        alu_valid = 1'b1; alu_dr = 5'd7; alu_data = 32'h2;
        tick();
        idle_inputs();
        sr1 = 5'd7; sr2 = 5'd8;
        #1;
        chk("t6_count2", 64'(count), 64'd2);
`ifdef WBQ_FWD_EN
        chk("t6_hit1", 64'(fwd_hit1), 64'd1);
        chk("t6_data1", 64'(fwd_data1), 64'h2);
        chk("t6_hit2", 64'(fwd_hit2), 64'd0);
        sr2 = 5'd7;
        #1;
        chk("t6_hit2_same", 64'(fwd_hit2), 64'd1);
        chk("t6_data2_same", 64'(fwd_data2), 64'h2);
`else
        chk("t6_hit1_off", 64'(fwd_hit1), 64'd0);
        chk("t6_data1_off", 64'(fwd_data1), 64'd0);
        chk("t6_hit2_off", 64'(fwd_hit2), 64'd0);
        chk("t6_data2_off", 64'(fwd_data2), 64'd0);
`endif
        tick(); tick();
        chk("t6_drained", 64'(count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    // Hard stop in case the sequence stalls.
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish by 20000");
        $fatal(1, "timeout");
    end

endmodule
